wm_phase_timer: RTL and testbench

//  Parametrised per-phase timer for the washing-machine controller. On a Start pulse it

---
 rtl/wm_timer_pkg.sv | 45 ++++
 rtl/wm_minute_prescaler.sv | 34 +++
 rtl/wm_phase_timer.sv | 137 +++++++++++++
 tb/tb_wm_phase_timer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wm_timer_pkg.sv
// Shared types for the washing-machine phase timer: phase codes,
// clock-select encodings, FSM states and the phase duration table.
package wm_timer_pkg;

   localparam int DUR_W = 8;

   typedef enum logic [2:0] {
      PH_A = 3'd0,
      PH_B = 3'd1,
      PH_C = 3'd2,
      PH_D = 3'd3,
      PH_E = 3'd4,
      PH_F = 3'd5
   } phase_e;

   typedef enum logic [1:0] {
      SEL_1MHZ = 2'd0,
      SEL_2MHZ = 2'd1,
      SEL_4MHZ = 2'd2,
      SEL_8MHZ = 2'd3
   } clk_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Phase length in minutes; unused codes 6/7 behave like F.
   function automatic logic [DUR_W-1:0] dur_min(input logic [2:0] ph);
      logic [DUR_W-1:0] d;
      d = '0;
      case (ph)
         PH_A:    d = 8'd1;
         PH_B:    d = 8'd2;
         PH_C:    d = 8'd5;
         PH_D:    d = 8'd2;
         PH_E:    d = 8'd1;
         default: d = 8'd0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/wm_minute_prescaler.sv
// Divides the clock down to one tick per minute; the period is
// CYC_PER_MIN_BASE shifted left by the latched clock select.
module wm_minute_prescaler
   import wm_timer_pkg::*;
#(
   parameter int CLK_SEL_W        = 2,
   parameter int CYC_PER_MIN_BASE = 60_000_000,
   parameter int CNT_W            = 32
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic [CLK_SEL_W-1:0] sel,
   output logic                 tick
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_last;

   assign w_last = (CNT_W'(CYC_PER_MIN_BASE) << sel) - CNT_W'(1);
   assign tick   = en && (r_cnt == w_last);

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/wm_phase_timer.sv
// Per-phase washing-machine timer: FSM, minute counter and outputs.
// Define WM_TIMER_REMAIN_EN to add the Remaining_min output.
module wm_phase_timer
   import wm_timer_pkg::*;
#(
   parameter int         CLK_SEL_W        = 2,
   parameter int         PHASE_W          = 3,
   parameter int         CYC_PER_MIN_BASE = 60_000_000,
   parameter int         CNT_W            = 32,
   parameter int         MIN_W            = 8,
   parameter logic [5:0] PAUSE_MASK       = 6'b010000
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 Start,
   input  logic                 Abort,
   input  logic                 Timer_pause,
   input  logic [CLK_SEL_W-1:0] CLK_freq,
   input  logic [PHASE_W-1:0]   Duration_clk_timer,
   output logic                 Busy,
   output logic                 Trigger_clk_timer,
   output logic                 Done_pulse
`ifdef WM_TIMER_REMAIN_EN
   ,
   output logic [MIN_W-1:0]     Remaining_min
`endif
);

   state_e                r_state;
   state_e                w_next;
   logic [CLK_SEL_W-1:0]  r_sel;
   logic [PHASE_W-1:0]    r_phase;
   logic [MIN_W-1:0]      r_min;
   logic                  r_done_p;

   logic [7:0]            w_mask;
   logic [2:0]            w_ph3;
   logic [MIN_W-1:0]      w_dur;
   logic [MIN_W-1:0]      w_min_nx;
   logic                  w_active;
   logic                  w_pause;
   logic                  w_en;
   logic                  w_clr;
   logic                  w_tick;
   logic                  w_expire;

   assign w_mask   = 8'(PAUSE_MASK);
   assign w_ph3    = 3'(r_phase);
   assign w_dur    = MIN_W'(dur_min(w_ph3));
   assign w_min_nx = r_min + MIN_W'(1);
   assign w_active = (r_state == ST_RUN) || (r_state == ST_PAUSED);
   assign w_pause  = Timer_pause && w_mask[w_ph3];
   assign w_clr    = Start || Abort;
   assign w_en     = w_active && !w_pause && !w_clr;

   // A zero-length phase finishes on the first cycle after Start.
   assign w_expire = w_en &&
                     ((w_dur == '0) || (w_tick && (w_min_nx == w_dur)));

   wm_minute_prescaler #(
      .CLK_SEL_W        (CLK_SEL_W),
      .CYC_PER_MIN_BASE (CYC_PER_MIN_BASE),
      .CNT_W            (CNT_W)
   ) u_presc (
      .CLK   (CLK),
      .RST_n (RST_n),
      .clr   (w_clr),
      .en    (w_en),
      .sel   (r_sel),
      .tick  (w_tick)
   );

   always_comb begin
      w_next = r_state;
      if (Abort) begin
         w_next = ST_IDLE;
      end else if (Start) begin
         w_next = ST_RUN;
      end else begin
         unique case (r_state)
            ST_RUN, ST_PAUSED: begin
               if (w_pause)       w_next = ST_PAUSED;
               else if (w_expire) w_next = ST_DONE;
               else               w_next = ST_RUN;
            end
            default: w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= '0;
         r_phase  <= '0;
         r_min    <= '0;
         r_done_p <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_done_p <= (w_next == ST_DONE) && (r_state != ST_DONE);
         if (Abort) begin
            r_min <= '0;
         end else if (Start) begin
            r_sel   <= CLK_freq;
            r_phase <= Duration_clk_timer;
            r_min   <= '0;
         end else if (w_tick) begin
            r_min <= w_min_nx;
         end
      end
   end

`ifdef WM_TIMER_REMAIN_EN
   logic [MIN_W-1:0] r_rem;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_rem <= '0;
      end else if (Abort) begin
         r_rem <= '0;
      end else if (Start) begin
         r_rem <= MIN_W'(dur_min(3'(Duration_clk_timer)));
      end else if (w_expire) begin
         r_rem <= '0;
      end else if (w_tick) begin
         r_rem <= w_dur - w_min_nx;
      end
   end

   assign Remaining_min = r_rem;
`endif

   assign Busy              = w_active;
   assign Trigger_clk_timer = (r_state == ST_DONE);
   assign Done_pulse        = r_done_p;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Scoreboard bench for wm_phase_timer with a 4-cycle base minute.
// Expected Done_pulse cycles are queued by stimulus, checked by a monitor.
module tb_wm_phase_timer;

   logic       CLK;
   logic       RST_n;
   logic       Start;
   logic       Abort;
   logic       Timer_pause;
   logic [1:0] CLK_freq;
   logic [2:0] Duration_clk_timer;
   logic       Busy;
   logic       Trigger_clk_timer;
   logic       Done_pulse;
`ifdef WM_TIMER_REMAIN_EN
   logic [7:0] Remaining_min;
`endif

   int n_cmp;
   int n_bad;
   int cyc;
   int sb[$];
   int k;
   int k2;

   wm_phase_timer #(.CYC_PER_MIN_BASE(4)) dut (
      .CLK                (CLK),
      .RST_n              (RST_n),
      .Start              (Start),
      .Abort              (Abort),
      .Timer_pause        (Timer_pause),
      .CLK_freq           (CLK_freq),
      .Duration_clk_timer (Duration_clk_timer),
      .Busy               (Busy),
      .Trigger_clk_timer  (Trigger_clk_timer),
      .Done_pulse         (Done_pulse)
`ifdef WM_TIMER_REMAIN_EN
      ,
      .Remaining_min      (Remaining_min)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every Done_pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (RST_n && Done_pulse) begin
         if (sb.size() == 0) begin
            chk("unexpected_done_cycle", cyc, -1);
         end else begin
            int e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e);
            chk("done_trigger", int'(Trigger_clk_timer), 1);
            chk("done_busy", int'(Busy), 0);
         end
      end
   end

   // dly < 0 means no Done_pulse is expected for this run.
   task automatic do_start(input int sel, input int ph, input int dly,
                           output int kk);
      @(negedge CLK);
      Start = 1'b1;
      CLK_freq = 2'(sel);
      Duration_clk_timer = 3'(ph);
      kk = cyc + 1;
      if (dly >= 0) sb.push_back(kk + dly);
      @(negedge CLK);
      Start = 1'b0;
   endtask

   task automatic wait_sb(input int budget);
      int t;
      t = 0;
      while (sb.size() != 0 && t < budget) begin
         @(negedge CLK);
         t++;
      end
      @(negedge CLK);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      cyc = 0;
      RST_n = 1'b0;
      Start = 1'b0;
      Abort = 1'b0;
      Timer_pause = 1'b0;
      CLK_freq = '0;
      Duration_clk_timer = '0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_trig", int'(Trigger_clk_timer), 0);
      chk("rst_done", int'(Done_pulse), 0);
      RST_n = 1'b1;
      @(negedge CLK);

      // 1: sel 0, phase B -> 2 min x 4 cycles
      do_start(0, 1, 8, k);
      chk("b_busy", int'(Busy), 1);
`ifdef WM_TIMER_REMAIN_EN
      chk("b_rem0", int'(Remaining_min), 2);
      repeat (4) @(negedge CLK);
      chk("b_rem1", int'(Remaining_min), 1);
`endif
      wait_sb(40);
      repeat (3) @(negedge CLK);
      chk("b_trig_hold", int'(Trigger_clk_timer), 1);
      chk("b_pulse_low", int'(Done_pulse), 0);

      // 2: sel 3, phase C -> 5 min x 32 cycles; later input changes ignored
      do_start(3, 2, 160, k);
      repeat (10) @(negedge CLK);
      CLK_freq = 2'd0;
      Duration_clk_timer = 3'd5;
      wait_sb(200);

      // 3: phase E honours pause, phase B does not
      do_start(0, 4, 14, k);
      @(negedge CLK);
      Timer_pause = 1'b1;
      repeat (5) @(negedge CLK);
      chk("e_paused_busy", int'(Busy), 1);
      repeat (5) @(negedge CLK);
      Timer_pause = 1'b0;
      wait_sb(40);
      do_start(0, 1, 8, k);
      @(negedge CLK);
      Timer_pause = 1'b1;
      repeat (10) @(negedge CLK);
      Timer_pause = 1'b0;
      wait_sb(40);

      // 4: zero-length phases F and code 7
      do_start(0, 5, 1, k);
`ifdef WM_TIMER_REMAIN_EN
      chk("f_rem", int'(Remaining_min), 0);
`endif
      wait_sb(10);
      do_start(2, 7, 1, k);
      wait_sb(10);

      // Restart on the cycle that would expire: only the new run completes
      do_start(0, 0, -1, k);
      repeat (2) @(negedge CLK);
      do_start(0, 0, 4, k2);
      chk("restart_at", k2, k + 4);
      wait_sb(20);

      // 5: Abort 3 cycles into RUN, then Start+Abort together
      do_start(0, 2, -1, k);
      repeat (2) @(negedge CLK);
      Abort = 1'b1;
      @(negedge CLK);
      Abort = 1'b0;
      chk("abort_busy", int'(Busy), 0);
      repeat (30) @(negedge CLK);
      chk("abort_trig", int'(Trigger_clk_timer), 0);
      Start = 1'b1;
      Abort = 1'b1;
      Duration_clk_timer = 3'd1;
      @(negedge CLK);
      Start = 1'b0;
      Abort = 1'b0;
      chk("sa_busy", int'(Busy), 0);
      repeat (12) @(negedge CLK);
      chk("sa_trig", int'(Trigger_clk_timer), 0);

      // 6: asynchronous reset mid-run
      do_start(0, 1, -1, k);
      repeat (3) @(negedge CLK);
      #2 RST_n = 1'b0;
      #1;
      chk("arst_busy", int'(Busy), 0);
      chk("arst_trig", int'(Trigger_clk_timer), 0);
      @(negedge CLK);
      RST_n = 1'b1;
      do_start(0, 1, 8, k);
      wait_sb(40);
      chk("done_trig", int'(Trigger_clk_timer), 1);
      do_start(0, 0, 4, k2);
      chk("redo_trig", int'(Trigger_clk_timer), 0);
      chk("redo_busy", int'(Busy), 1);
      wait_sb(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
